// File: rtl/aes_scan_result_checker.sv
// aes_scan_result_checker: shifts the AES ciphertext out of the test chip and checks it against the known answer.
module aes_scan_result_checker #(
    parameter int WIDTH = 128,
    parameter int CLK_DIV = 4,
    parameter int TIMEOUT = 4096,
    parameter logic [WIDTH-1:0] EXPECTED = 128'h69c4e0d86a7b0430d8cdb78070b4c55a
) (
    input  logic             CLK,
    input  logic             reset1,
    input  logic             start,
    input  logic             BSY,
    input  logic             SO,
    output logic             SCLK,
    output logic             SE,
    output logic [WIDTH-1:0] data_out,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout
);
    localparam int WW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [2:0] IDLE = 3'd0, WAIT_BSY = 3'd1, SHIFT = 3'd2, COMPARE = 3'd3, DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sclk_q, sclk_d, se_q, se_d, done_q, done_d;
    logic             pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;

    always_comb begin
        state_d = state_q;
        wait_d = wait_q;
        bit_d = bit_q;
        div_d = div_q;
        data_d = data_q;
        sclk_d = sclk_q;
        se_d = se_q;
        done_d = done_q;
        pass_d = pass_q;
        fail_d = fail_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = WAIT_BSY;
                wait_d = '0;
                data_d = '0;
                done_d = 1'b0;
                pass_d = 1'b0;
                fail_d = 1'b0;
                timeout_d = 1'b0;
            end
            WAIT_BSY: if (!BSY) begin
                state_d = SHIFT;
                se_d = 1'b1;
                sclk_d = 1'b0;
                div_d = '0;
                bit_d = '0;
            end else if (wait_q == WW'(TIMEOUT - 1)) begin
                state_d = DONE;
                done_d = 1'b1;
                timeout_d = 1'b1;
                fail_d = 1'b1;
                pass_d = 1'b0;
            end else begin
                wait_d = wait_q + 1'b1;
            end
            // each SCLK half-period is CLK_DIV cycles; SO is sampled as SCLK rises
            SHIFT: if (div_q == DW'(CLK_DIV - 1)) begin
                div_d = '0;
                sclk_d = !sclk_q;
                if (!sclk_q) begin
                    data_d = {data_q[WIDTH-2:0], SO};
                    bit_d = bit_q + 1'b1;
                end else if (bit_q == BW'(WIDTH)) begin
                    se_d = 1'b0;
                    state_d = COMPARE;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
            COMPARE: begin
                pass_d = data_q == EXPECTED;
                fail_d = data_q != EXPECTED;
                done_d = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset1) begin
            state_q <= IDLE;
            wait_q <= '0;
            bit_q <= '0;
            div_q <= '0;
            data_q <= '0;
            sclk_q <= 1'b0;
            se_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            bit_q <= bit_d;
            div_q <= div_d;
            data_q <= data_d;
            sclk_q <= sclk_d;
            se_q <= se_d;
            done_q <= done_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    assign SCLK = sclk_q;
    assign SE = se_q;
    assign data_out = data_q;
    assign done = done_q;
    assign pass = pass_q;
    assign fail = fail_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_aes_scan_result_checker.sv
// tb_aes_scan_result_checker: two instances (CLK_DIV=4 default, CLK_DIV=1 with short timeout) driven by chip models.
module tb_aes_scan_result_checker;
    localparam logic [127:0] KAT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int TO1 = 64;

    typedef struct {
        int d;
        logic [127:0] data;
        logic p, f, t;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v, start_v, bsy_v, sclk_o, se_o, done_o, pass_o, fail_o, to_o;
    logic so0, so1;
    logic [127:0] dout [2];
    logic [127:0] word [2];
    exp_t sb [$];
    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // chip model: SO presents bit (falls since SE rose), advancing on each SCLK fall
    int falls0 = 0, falls1 = 0, base0 = 0, base1 = 0;
    always @(negedge sclk_o[0]) falls0 <= falls0 + 1;
    always @(negedge sclk_o[1]) falls1 <= falls1 + 1;
    always @(posedge se_o[0]) base0 <= falls0;
    always @(posedge se_o[1]) base1 <= falls1;
    assign so0 = (falls0 - base0 < 128) ? word[0][7'(127 - falls0 + base0)] : 1'b0;
    assign so1 = (falls1 - base1 < 128) ? word[1][7'(127 - falls1 + base1)] : 1'b0;

    // monitor: SCLK rise times, bits captured at each rise, SE/SCLK occupancy
    int rise_cyc [2][256];
    logic cap_bit [2][256];
    int rises [2] = '{0, 0};
    int se_cnt [2] = '{0, 0};
    int sclk_hi [2] = '{0, 0};
    int sclk_out [2] = '{0, 0};
    int se_rise [2] = '{0, 0};
    logic [1:0] se_p = 2'b00, sclk_p = 2'b00;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (se_o[i] && !se_p[i]) se_rise[i] <= cyc;
            if (sclk_o[i] && !sclk_p[i]) begin
                rise_cyc[i][rises[i] % 256] <= cyc;
                cap_bit[i][rises[i] % 256] <= dout[i][0];
                rises[i] <= rises[i] + 1;
            end
            se_cnt[i] <= se_cnt[i] + int'(se_o[i]);
            sclk_hi[i] <= sclk_hi[i] + int'(sclk_o[i]);
            sclk_out[i] <= sclk_out[i] + int'(sclk_o[i] && !se_o[i]);
        end
        se_p <= se_o;
        sclk_p <= sclk_o;
    end

    aes_scan_result_checker dut0 (
        .CLK(clk), .reset1(rst_v[0]), .start(start_v[0]), .BSY(bsy_v[0]), .SO(so0),
        .SCLK(sclk_o[0]), .SE(se_o[0]), .data_out(dout[0]), .done(done_o[0]),
        .pass(pass_o[0]), .fail(fail_o[0]), .timeout(to_o[0])
    );
    aes_scan_result_checker #(.CLK_DIV(1), .TIMEOUT(TO1)) dut1 (
        .CLK(clk), .reset1(rst_v[1]), .start(start_v[1]), .BSY(bsy_v[1]), .SO(so1),
        .SCLK(sclk_o[1]), .SE(se_o[1]), .data_out(dout[1]), .done(done_o[1]),
        .pass(pass_o[1]), .fail(fail_o[1]), .timeout(to_o[1])
    );

    function automatic int cdiv(input int d);
        return d == 0 ? 4 : 1;
    endfunction

    task automatic run_kat(input int d, input logic [127:0] w, input int wt, input bit push, output int n);
        exp_t e;
        word[d] = w;
        @(posedge clk);
        #1;
        n = cyc;
        start_v[d] = 1'b1;
        bsy_v[d] = 1'b1;
        e.d = d;
        e.data = w;
        e.p = w == KAT;
        e.f = w != KAT;
        e.t = 1'b0;
        e.cyc = n + 3 + wt + 256 * cdiv(d);
        if (push) sb.push_back(e);
        @(posedge clk);
        #1 start_v[d] = 1'b0;
        repeat (wt) @(posedge clk);
        #1 bsy_v[d] = 1'b0;
    endtask

    task automatic finish_run;
        exp_t e;
        int k;
        int d = sb[0].d;
        for (k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (done_o[d]) break;
        end
        e = sb.pop_front();
        checks++;
        if (k == 6000 || cyc != e.cyc) begin
            failures++;
            $display("FAIL done_cycle dut%0d got %0d exp %0d", d, k == 6000 ? -1 : cyc, e.cyc);
        end
        checks++;
        if (dout[d] !== e.data) begin
            failures++;
            $display("FAIL data_out dut%0d got %h exp %h", d, dout[d], e.data);
        end
        checks++;
        if (pass_o[d] !== e.p) begin
            failures++;
            $display("FAIL pass dut%0d got %b exp %b", d, pass_o[d], e.p);
        end
        checks++;
        if (fail_o[d] !== e.f) begin
            failures++;
            $display("FAIL fail dut%0d got %b exp %b", d, fail_o[d], e.f);
        end
        checks++;
        if (to_o[d] !== e.t) begin
            failures++;
            $display("FAIL timeout dut%0d got %b exp %b", d, to_o[d], e.t);
        end
    endtask

    task automatic test_reset;
        rst_v = 2'b11;
        start_v = 2'b00;
        bsy_v = 2'b00;
        word[0] = '0;
        word[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst_v = 2'b00;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({sclk_o[d], se_o[d], done_o[d], pass_o[d], fail_o[d], to_o[d]} !== 6'b0) begin
                failures++;
                $display("FAIL reset_flags dut%0d got %b exp 000000", d,
                         {sclk_o[d], se_o[d], done_o[d], pass_o[d], fail_o[d], to_o[d]});
            end
            checks++;
            if (dout[d] !== '0) begin
                failures++;
                $display("FAIL reset_data dut%0d got %h exp 0", d, dout[d]);
            end
        end
    endtask

    task automatic test_known_answer;
        int n;
        run_kat(0, KAT, 20, 1'b1, n);
        finish_run();
    endtask

    task automatic test_bit_error;
        int n;
        run_kat(0, KAT ^ 128'h1, 5, 1'b1, n);
        finish_run();
    endtask

    task automatic test_timing(input int d);
        int r0 = rises[d], s0 = se_cnt[d], h0 = sclk_hi[d], o0 = sclk_out[d];
        int c = cdiv(d);
        int n, bad = -1, badb = -1;
        logic [127:0] w = {$urandom, $urandom, $urandom, $urandom};
        run_kat(d, w, 3, 1'b1, n);
        finish_run();
        checks++;
        if (rises[d] - r0 != 128) begin
            failures++;
            $display("FAIL sclk_rises dut%0d got %0d exp 128", d, rises[d] - r0);
        end
        checks++;
        if (se_cnt[d] - s0 != 256 * c) begin
            failures++;
            $display("FAIL se_high_cycles dut%0d got %0d exp %0d", d, se_cnt[d] - s0, 256 * c);
        end
        checks++;
        if (sclk_hi[d] - h0 != 128 * c) begin
            failures++;
            $display("FAIL sclk_duty dut%0d got %0d exp %0d", d, sclk_hi[d] - h0, 128 * c);
        end
        checks++;
        if (sclk_out[d] - o0 != 0) begin
            failures++;
            $display("FAIL sclk_outside_se dut%0d got %0d exp 0", d, sclk_out[d] - o0);
        end
        checks++;
        if (se_rise[d] != n + 5) begin
            failures++;
            $display("FAIL se_rise_cycle dut%0d got %0d exp %0d", d, se_rise[d], n + 5);
        end
        for (int k = 0; k < 128; k++) begin
            if (bad < 0 && rise_cyc[d][(r0 + k) % 256] - se_rise[d] != c * (2 * k + 1)) bad = k;
            if (badb < 0 && cap_bit[d][(r0 + k) % 256] !== w[127 - k]) badb = k;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL rise_offset dut%0d bit %0d got %0d exp %0d", d, bad,
                     rise_cyc[d][(r0 + bad) % 256] - se_rise[d], c * (2 * bad + 1));
        end
        checks++;
        if (badb >= 0) begin
            failures++;
            $display("FAIL capture_bit dut%0d bit %0d got %b exp %b", d, badb,
                     cap_bit[d][(r0 + badb) % 256], w[127 - badb]);
        end
    endtask

    task automatic test_timeout(input int d);
        exp_t e;
        int r0 = rises[d], s0 = se_cnt[d];
        word[d] = KAT;
        @(posedge clk);
        #1;
        e.d = d;
        e.data = '0;
        e.p = 1'b0;
        e.f = 1'b1;
        e.t = 1'b1;
        e.cyc = cyc + 1 + (d == 0 ? 4096 : TO1);
        sb.push_back(e);
        start_v[d] = 1'b1;
        bsy_v[d] = 1'b1;
        @(posedge clk);
        #1 start_v[d] = 1'b0;
        finish_run();
        checks++;
        if (rises[d] != r0 || se_cnt[d] != s0) begin
            failures++;
            $display("FAIL timeout_quiet dut%0d got rises=%0d se=%0d exp 0 0", d, rises[d] - r0, se_cnt[d] - s0);
        end
        bsy_v[d] = 1'b0;
    endtask

    task automatic test_rerun;
        exp_t e;
        word[1] = KAT ^ {1'b1, 127'b0};
        @(posedge clk);
        #1;
        e.d = 1;
        e.data = word[1];
        e.p = 1'b0;
        e.f = 1'b1;
        e.t = 1'b0;
        e.cyc = cyc + 3 + 256;
        sb.push_back(e);
        start_v[1] = 1'b1;
        bsy_v[1] = 1'b1;
        @(posedge clk);
        #1 start_v[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({done_o[1], pass_o[1], fail_o[1], to_o[1]} !== 4'b0 || dout[1] !== '0) begin
            failures++;
            $display("FAIL rerun_clear got %b data %h exp 0000 data 0",
                     {done_o[1], pass_o[1], fail_o[1], to_o[1]}, dout[1]);
        end
        bsy_v[1] = 1'b0;
        finish_run();
    endtask

    task automatic test_start_ignored;
        int n;
        run_kat(1, KAT, 4, 1'b1, n);
        repeat (50) @(posedge clk);
        #1 start_v[1] = 1'b1;
        @(posedge clk);
        #1 start_v[1] = 1'b0;
        finish_run();
    endtask

    task automatic test_reset_mid_shift;
        int n, k, busy = 0;
        int r0 = rises[0];
        run_kat(0, KAT, 2, 1'b0, n);
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (rises[0] - r0 >= 60) break;
        end
        checks++;
        if (k == 3000 || sclk_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL reach_bit60 got rises=%0d sclk=%b exp 60 1", rises[0] - r0, sclk_o[0]);
        end
        rst_v[0] = 1'b1;
        @(posedge clk);
        #1 rst_v[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({sclk_o[0], se_o[0], done_o[0], pass_o[0], fail_o[0], to_o[0]} !== 6'b0 || dout[0] !== '0) begin
            failures++;
            $display("FAIL mid_reset got %b data %h exp 000000 data 0",
                     {sclk_o[0], se_o[0], done_o[0], pass_o[0], fail_o[0], to_o[0]}, dout[0]);
        end
        repeat (5) begin
            @(negedge clk);
            busy += int'(se_o[0] || done_o[0]);
        end
        checks++;
        if (busy != 0) begin
            failures++;
            $display("FAIL idle_after_reset got %0d exp 0", busy);
        end
        run_kat(0, KAT, 0, 1'b1, n);
        finish_run();
    endtask

    initial begin
        test_reset();
        test_known_answer();
        test_bit_error();
        test_timing(0);
        test_timing(1);
        test_timeout(1);
        test_rerun();
        test_start_ignored();
        test_reset_mid_shift();
        test_timeout(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_scan_result_checker.md
# aes_scan_result_checker

Downstream stage of the AES test-chip scan driver on the FPGA test board. Once the chip drops BSY, this block generates SCLK/SE and shifts the 128-bit ciphertext out of the chip's SO pin, MSB first. It compares the captured word against a known-answer constant and drives the board pass/fail LEDs. It runs once per `start` pulse from the top-level sequencer.

## Interface
Parameters:
- `WIDTH`, 128: ciphertext bits shifted out.
- `CLK_DIV`, 4: SCLK half-period in CLK cycles (≥1).
- `TIMEOUT`, 4096: max CLK cycles to wait for BSY low.
- `EXPECTED`, 128'h69c4e0d86a7b0430d8cdb78070b4c55a: FIPS-197 AES-128 known answer.

Ports:
- `CLK`  in  1  system clock; sole clock domain.
- `reset1`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to read and check a result.
- `BSY`  in  1  chip busy; high while encryption runs.
- `SO`  in  1  chip scan-out data, changes on SCLK falling edge.
- `SCLK`  out  1  scan clock to chip (registered).
- `SE`  out  1  scan enable to chip (registered), high during shift.
- `data_out`  out  WIDTH  captured ciphertext.
- `done`  out  1  high in DONE until next accepted start or reset.
- `pass`  out  1  result matched EXPECTED (led1).
- `fail`  out  1  mismatch or timeout (led2).
- `timeout`  out  1  BSY never fell within TIMEOUT.

## Operation
- Reset values: SCLK=0, SE=0, data_out=0, done=0, pass=0, fail=0, timeout=0, state=IDLE, all counters 0.
- States:
  - IDLE: on start=1 → WAIT_BSY; clear done/pass/fail/timeout/data_out; zero wait counter.
  - WAIT_BSY:
    - BSY=0 → SHIFT with SE=1, SCLK=0, div and bit counters 0.
    - else increment wait counter; reaching TIMEOUT-1 with BSY still high → DONE with timeout=1, fail=1, pass=0.
  - SHIFT:
    - div counter counts 0..CLK_DIV-1; at terminal count toggle SCLK and reset div counter.
    - On the cycle SCLK goes 0→1, capture SO: data_out <= {data_out[WIDTH-2:0], SO}; bit counter +1.
    - After the WIDTH-th rising edge, SCLK completes its high half then returns to 0. On that same edge SE→0 and state → COMPARE.
  - COMPARE (1 cycle): pass = (data_out == EXPECTED), fail = !pass → DONE.
  - DONE: done=1, outputs held. start=1 → behaves as IDLE accepting start.
- start in WAIT_BSY/SHIFT/COMPARE ignored.
- reset1 mid-operation: every output and state return to reset values on that edge; SCLK forced 0 even mid-high-phase.
- Counters: wait counter sized clog2(TIMEOUT), bit counter clog2(WIDTH+1), no wrap in normal flow.

## Timing
- start sampled at edge N → WAIT_BSY at N+1.
- BSY sampled low at edge M → SHIFT from M+1, SE=1 from M+1.
- First SCLK rise at M+1+CLK_DIV. Bit k (0-based, MSB first) captured at M+1+CLK_DIV·(2k+1).
- SHIFT length 2·WIDTH·CLK_DIV cycles; SE low and COMPARE at M+1+2·WIDTH·CLK_DIV.
- pass/fail/done valid one cycle later; total start→done = 3+wait+2·WIDTH·CLK_DIV cycles (1027+wait at defaults).
- BSY=0 already at start: zero-wait path, SHIFT at N+2.
- SCLK duty exactly 50%; no glitches; SE high covers all WIDTH rising edges.

## Test plan
- Known answer: BSY low 20 cycles after start, chip model shifts 69c4…c55a on SCLK falls → data_out=EXPECTED, pass=1, fail=0, done=1 at start+1047.
- Single-bit error: model flips LSB (…c55b) → pass=0, fail=1, data_out=…c55b.
- Timeout: BSY held high → at start+1+TIMEOUT timeout=1, fail=1, done=1, SE and SCLK never toggled.
- Timing check: CLK_DIV=1 and CLK_DIV=4 → exactly 128 SCLK rises, 50% duty, SE high only during shift, bit k captured at the formula cycle.
- Reset mid-shift after 60 bits → next edge SCLK=0, SE=0, data_out=0, state IDLE; following start completes normally with pass=1.
- start re-pulsed during SHIFT ignored; start in DONE clears flags and reruns.
